stopwatch_core: RTL and testbench

//  - Stopwatch datapath downstream of the mode FSM. Consumes its count-enable and lap/load-enable strobes.
//  - Keeps a BCD MM:SS elapsed-time count and drives a lap-freezable display register to the 7-seg mux.
//  - Contains its own clock prescaler, so seconds advance only while counting is enabled.

---
 rtl/stopwatch_core_pkg.sv | 29 ++
 rtl/stopwatch_core_bcd_digit_cnt.sv | 31 +++
 rtl/stopwatch_core.sv | 109 ++++++++++
 tb/tb_stopwatch_core.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// stopwatch_core_pkg - shared constants and types for the stopwatch datapath.
//   BCD_W          width of one BCD digit
//   SEC_TENS_MAX   last legal value of a tens digit (seconds and minutes tens)
//   ONES_MAX       last legal value of a ones digit
//   ENABLED/DISABLED  strobe levels used by the mode FSM
//   stw_time_t     MM:SS as four BCD digits
package stopwatch_core_pkg;

  localparam int   BCD_W        = 4;
  localparam int   SEC_TENS_MAX = 5;
  localparam int   ONES_MAX     = 9;
  localparam logic ENABLED      = 1'b1;
  localparam logic DISABLED     = 1'b0;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } stw_time_t;

  // Digit chain index 0 = sec_ones .. 3 = min_tens; even positions are ones digits.
  function automatic int digit_max(input int idx);
    return (idx % 2 == 0) ? ONES_MAX : SEC_TENS_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// bcd_digit_cnt - one wrapping BCD digit, chained through carry.
//   clk    system clock
//   rst    asynchronous active-high reset
//   inc    advance by one this cycle
//   clr    synchronous zero, wins over inc
//   q      digit value, 0..MAX
//   carry  inc & (q==MAX): this digit wraps and the next one advances
module bcd_digit_cnt
  import stopwatch_core_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t Q_MAX = bcd_t'(MAX);

  assign carry = inc & (q == Q_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == Q_MAX) ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core - BCD MM:SS stopwatch datapath with lap-freezable display.
//   clk       system clock
//   rst       asynchronous active-high reset (released synchronously inside)
//   count_en  1 = running; prescaler and count advance only while high
//   lap_en    1 = display frozen; live count keeps running
//   clear     synchronous zero of prescaler, live, display (and ovf)
//   min_tens/min_ones/sec_tens/sec_ones  display digits, one clk behind live
//   running   registered count_en
//   ovf       sticky 59:59->00:00 wrap flag, only when STW_OVERFLOW_EN is defined
// Optional feature macro: STW_OVERFLOW_EN
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             lap_en,
  input  logic             clear,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running
`ifdef STW_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Reset asserts immediately but releases on a clock edge, so no flop sees
  // a release racing the clock.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_i = rst_sync[1];

  // Prescaler: holds while paused so a partial second survives pause/resume.
  logic [CNT_W-1:0] presc;
  logic             tick;

  assign tick = count_en & (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)         presc <= '0;
    else if (clear)    presc <= '0;
    else if (tick)     presc <= '0;
    else if (count_en) presc <= presc + 1'b1;
  end

  // Live count: four digits chained by carry, index 0 = sec_ones.
  logic [3:0][BCD_W-1:0] live;
  logic [3:0]            inc;
  logic [3:0]            carry;

  assign inc = {carry[2:0], tick};

  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_digit_cnt #(.MAX(digit_max(g))) u_dig (
      .clk   (clk),
      .rst   (rst_i),
      .inc   (inc[g]),
      .clr   (clear),
      .q     (live[g]),
      .carry (carry[g])
    );
  end

  // Display: follows live one clk behind, holds while lapped.
  stw_time_t disp;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      disp    <= '0;
      running <= 1'b0;
    end else begin
      running <= count_en;
      if (clear)                 disp <= '0;
      else if (lap_en == DISABLED) disp <= {live[3], live[2], live[1], live[0]};
    end
  end

  assign min_tens = disp.min_tens;
  assign min_ones = disp.min_ones;
  assign sec_tens = disp.sec_tens;
  assign sec_ones = disp.sec_ones;

`ifdef STW_OVERFLOW_EN
  // min_tens only carries when every lower digit is at its max: 59:59 wrap.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)         ovf <= 1'b0;
    else if (clear)    ovf <= 1'b0;
    else if (carry[3]) ovf <= 1'b1;
  end
`else
  logic wrap_unused;
  assign wrap_unused = carry[3];
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core - directed self-checking bench for stopwatch_core (TICK_DIV=4).
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       count_en = 1'b0;
  logic       lap_en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running;
`ifdef STW_OVERFLOW_EN
  logic       ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] disp;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  stopwatch_core #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .lap_en   (lap_en),
    .clear    (clear),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running)
`ifdef STW_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n whole seconds from a prescaler at 0; leaves the prescaler at 0.
  task automatic run_ticks(input int n);
    count_en = 1'b1;
    repeat (4 * n) step();
    count_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1 chk("rst_disp", disp, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_disp", disp, 16'h0000);

    // 40 clk of counting = 10 ticks
    count_en = 1'b1;
    step();
    chk("running_on", {15'd0, running}, 16'd1);
    repeat (39) step();
    chk("cnt40_disp_lag", disp, 16'h0009);
    count_en = 1'b0;
    step();
    chk("cnt40_disp", disp, 16'h0010);
    chk("running_off", {15'd0, running}, 16'd0);

    // pause/resume keeps the partial second
    do_clear();
    chk("clear_disp", disp, 16'h0000);
    count_en = 1'b1; repeat (2) step();
    count_en = 1'b0; repeat (10) step();
    chk("pause_no_tick", disp, 16'h0000);
    count_en = 1'b1; repeat (2) step();
    count_en = 1'b0;
    chk("resume_lag", disp, 16'h0000);
    step();
    chk("resume_tick", disp, 16'h0001);

    // lap freeze
    do_clear();
    run_ticks(5);
    step();
    chk("lap_pre", disp, 16'h0005);
    lap_en = 1'b1;
    count_en = 1'b1;
    repeat (20) step();
    chk("lap_frozen", disp, 16'h0005);
    count_en = 1'b0;
    lap_en = 1'b0;
    step();
    chk("lap_release", disp, 16'h0010);

    // wrap at 59:59
    do_clear();
    run_ticks(3598);
    step();
    chk("wrap_5958", disp, 16'h5958);
    run_ticks(1);
    step();
    chk("wrap_5959", disp, 16'h5959);
`ifdef STW_OVERFLOW_EN
    chk("ovf_before", {15'd0, ovf}, 16'd0);
`endif
    run_ticks(1);
    step();
    chk("wrap_0000", disp, 16'h0000);
`ifdef STW_OVERFLOW_EN
    chk("ovf_set", {15'd0, ovf}, 16'd1);
`endif
    run_ticks(1);
    step();
    chk("wrap_continue", disp, 16'h0001);
`ifdef STW_OVERFLOW_EN
    chk("ovf_sticky", {15'd0, ovf}, 16'd1);
`endif

    // clear on the same edge as a tick at 03:27
    do_clear();
    run_ticks(207);
    step();
    chk("pre_clear_0327", disp, 16'h0327);
    count_en = 1'b1;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_on_tick", disp, 16'h0000);
`ifdef STW_OVERFLOW_EN
    chk("ovf_cleared", {15'd0, ovf}, 16'd0);
`endif
    repeat (4) step();
    chk("next_tick_lag", disp, 16'h0000);
    step();
    chk("next_tick_4clk", disp, 16'h0001);
    count_en = 1'b0;

    // async reset mid-count at 12:34
    do_clear();
    run_ticks(754);
    step();
    chk("pre_rst_1234", disp, 16'h1234);
    count_en = 1'b1;
    step(); step();
    #2 rst = 1'b1;
    #1 chk("async_rst_disp", disp, 16'h0000);
    chk("async_rst_running", {15'd0, running}, 16'd0);
    count_en = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("after_rst_disp", disp, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
